// File: rtl/bit_stuffer_if.sv
// Serial bitstream link between the packet serializer, the bit stuffer and the NRZI encoder.
// master = upstream serializer side, slave = bit stuffer side.
interface bit_stuffer_if;
    logic       bstr_in;
    logic [1:0] bstr_in_ready;
    logic       stall;
    logic       bstr_out;
    logic [1:0] bstr_out_ready;

    modport master (
        output bstr_in,
        output bstr_in_ready,
        input  stall,
        input  bstr_out,
        input  bstr_out_ready
    );

    modport slave (
        input  bstr_in,
        input  bstr_in_ready,
        output stall,
        output bstr_out,
        output bstr_out_ready
    );
endinterface

// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every STUFF_LEN consecutive 1s and stalls upstream meanwhile.
// Optional BSTUFF_COUNT_EN adds stuff_count, the number of stuffed bits in the current/last packet.
module bit_stuffer #(
    parameter int unsigned STUFF_LEN = 6
) (
    input  logic          clk,
    input  logic          rst_b,
    bit_stuffer_if.slave  bus
`ifdef BSTUFF_COUNT_EN
    ,
    output logic [3:0]    stuff_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS  = 2'b01,
        STUFF = 2'b10
    } state_e;

    localparam logic [2:0] LAST_ONE = 3'(STUFF_LEN - 1);

    state_e     state_q;
    logic [2:0] ones_q;
    logic [1:0] ptype_q;
    logic       out_bit_q;
    logic [1:0] out_type_q;
    logic       stall_q;

    logic [2:0] ones_d;
    logic [2:0] ones_start_s;
    logic       in_valid_s;

    // Run-length arithmetic for the bit currently on the input.
    always_comb begin
        in_valid_s   = (bus.bstr_in_ready != 2'b00);
        ones_start_s = {2'b00, bus.bstr_in};
        if (bus.bstr_in) begin
            ones_d = ones_q + 3'd1;
        end else begin
            ones_d = 3'd0;
        end
    end

    // Stuffing FSM; every output is loaded here so nothing reaches the ports combinationally.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            ones_q     <= 3'd0;
            ptype_q    <= 2'b00;
            out_bit_q  <= 1'b1;
            out_type_q <= 2'b00;
            stall_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    stall_q <= 1'b0;
                    if (in_valid_s) begin
                        state_q    <= PASS;
                        ptype_q    <= bus.bstr_in_ready;
                        out_bit_q  <= bus.bstr_in;
                        out_type_q <= bus.bstr_in_ready;
                        ones_q     <= ones_start_s;
                    end else begin
                        out_bit_q  <= 1'b1;
                        out_type_q <= 2'b00;
                        ones_q     <= 3'd0;
                    end
                end
                PASS: begin
                    if (!in_valid_s) begin
                        state_q    <= IDLE;
                        out_bit_q  <= 1'b1;
                        out_type_q <= 2'b00;
                        ones_q     <= 3'd0;
                        stall_q    <= 1'b0;
                    end else if (bus.bstr_in_ready != ptype_q) begin
                        // Type change without a gap is a new packet: the run restarts here.
                        ptype_q    <= bus.bstr_in_ready;
                        out_bit_q  <= bus.bstr_in;
                        out_type_q <= bus.bstr_in_ready;
                        ones_q     <= ones_start_s;
                        stall_q    <= 1'b0;
                    end else begin
                        out_bit_q  <= bus.bstr_in;
                        out_type_q <= ptype_q;
                        if (bus.bstr_in && (ones_q == LAST_ONE)) begin
                            state_q <= STUFF;
                            ones_q  <= 3'd0;
                            stall_q <= 1'b1;
                        end else begin
                            ones_q  <= ones_d;
                            stall_q <= 1'b0;
                        end
                    end
                end
                STUFF: begin
                    // Stuffed 0 keeps the old packet type even if upstream already went idle.
                    out_bit_q  <= 1'b0;
                    out_type_q <= ptype_q;
                    ones_q     <= 3'd0;
                    stall_q    <= 1'b0;
                    if (in_valid_s) begin
                        state_q <= PASS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ones_q     <= 3'd0;
                    ptype_q    <= 2'b00;
                    out_bit_q  <= 1'b1;
                    out_type_q <= 2'b00;
                    stall_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall          = stall_q;
    assign bus.bstr_out       = out_bit_q;
    assign bus.bstr_out_ready = out_type_q;

`ifdef BSTUFF_COUNT_EN
    logic [3:0] stuff_cnt_q;
    logic       new_pkt_s;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        if (v == 4'd15) begin
            return 4'd15;
        end else begin
            return v + 4'd1;
        end
    endfunction

    // A packet starts on leaving IDLE or on a type change while passing bits.
    always_comb begin
        if (!in_valid_s) begin
            new_pkt_s = 1'b0;
        end else if (state_q == IDLE) begin
            new_pkt_s = 1'b1;
        end else if ((state_q == PASS) && (bus.bstr_in_ready != ptype_q)) begin
            new_pkt_s = 1'b1;
        end else begin
            new_pkt_s = 1'b0;
        end
    end

    // Per-packet stuffed-bit counter, saturating.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stuff_cnt_q <= 4'd0;
        end else if (new_pkt_s) begin
            stuff_cnt_q <= 4'd0;
        end else if (state_q == STUFF) begin
            stuff_cnt_q <= sat_inc4(stuff_cnt_q);
        end else begin
            stuff_cnt_q <= stuff_cnt_q;
        end
    end

    assign stuff_count = stuff_cnt_q;
`endif

endmodule

// File: tb/tb_bit_stuffer.sv
// Self-checking bench for bit_stuffer: directed packets plus random packets against a symbol-level model.
// Honours BSTUFF_COUNT_EN when defined.
module tb_bit_stuffer;

    localparam int STUFF_LEN = 6;

    logic clk = 1'b0;
    logic rst_b;

    bit_stuffer_if bus ();

`ifdef BSTUFF_COUNT_EN
    logic [3:0] stuff_count;
`endif

    bit_stuffer #(.STUFF_LEN(STUFF_LEN)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
`ifdef BSTUFF_COUNT_EN
        ,
        .stuff_count (stuff_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic       sym_bit[$];
    logic [1:0] sym_type[$];
    logic [3:0] exp_q[$];
    int         exp_stuffs;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic add_pkt(input logic [1:0] t, input int n, input logic [31:0] bits);
        for (int i = 0; i < n; i++) begin
            sym_bit.push_back(bits[n - 1 - i]);
            sym_type.push_back(t);
        end
    endtask

    task automatic add_rand_pkt(input logic [1:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            sym_bit.push_back($urandom_range(0, 5) != 0);
            sym_type.push_back(t);
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            sym_bit.push_back(1'b0);
            sym_type.push_back(2'b00);
        end
    endtask

    // Reference: each input symbol yields one output slot {stall, bit, type};
    // the STUFF_LEN-th consecutive 1 of a packet is followed by an extra 0 slot.
    task automatic build_model();
        int         run;
        logic [1:0] prev_t;
        exp_q.delete();
        run    = 0;
        prev_t = 2'b00;
        for (int i = 0; i < sym_bit.size(); i++) begin
            if (sym_type[i] == 2'b00) begin
                exp_q.push_back({1'b0, 1'b1, 2'b00});
                run    = 0;
                prev_t = 2'b00;
            end else begin
                if (sym_type[i] != prev_t) begin
                    run        = 0;
                    exp_stuffs = 0;
                    prev_t     = sym_type[i];
                end
                run = sym_bit[i] ? run + 1 : 0;
                if (run == STUFF_LEN) begin
                    exp_q.push_back({1'b1, sym_bit[i], sym_type[i]});
                    exp_q.push_back({1'b0, 1'b0, sym_type[i]});
                    run = 0;
                    if (exp_stuffs < 15) exp_stuffs++;
                end else begin
                    exp_q.push_back({1'b0, sym_bit[i], sym_type[i]});
                end
            end
        end
    endtask

    task automatic drive(input int idx);
        if (idx < sym_bit.size()) begin
            bus.bstr_in       = sym_bit[idx];
            bus.bstr_in_ready = sym_type[idx];
        end else begin
            bus.bstr_in       = 1'b0;
            bus.bstr_in_ready = 2'b00;
        end
    endtask

    // Plays the queued symbols as a stall-honouring serializer; call at a negedge.
    task automatic run_stream(input string tag);
        int   idx;
        logic prev_stall;
        build_model();
        idx        = 0;
        prev_stall = 1'b0;
        drive(idx);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check(tag, {bus.stall, bus.bstr_out, bus.bstr_out_ready}, exp_q[k]);
            if (!prev_stall) idx++;
            prev_stall = bus.stall;
            drive(idx);
        end
`ifdef BSTUFF_COUNT_EN
        check({tag, "_cnt"}, stuff_count, 4'(exp_stuffs));
`endif
        sym_bit.delete();
        sym_type.delete();
    endtask

    initial begin
        logic [1:0] t;
        logic [1:0] last_t;
        int         gap;

        exp_stuffs        = 0;
        rst_b             = 1'b0;
        bus.bstr_in       = 1'b0;
        bus.bstr_in_ready = 2'b00;
        repeat (3) @(negedge clk);
        check("reset", {bus.stall, bus.bstr_out, bus.bstr_out_ready}, 4'b0100);
`ifdef BSTUFF_COUNT_EN
        check("reset_cnt", stuff_count, 4'd0);
`endif
        rst_b = 1'b1;

        add_pkt(2'b01, 8, 32'b11111101);
        add_idle(2);
        run_stream("t1_token_stuff");

        add_pkt(2'b01, 8, 32'b11111011);
        add_idle(2);
        run_stream("t2_no_stuff");

        add_pkt(2'b10, 12, 32'hFFF);
        add_idle(2);
        run_stream("t3_double_stuff");

        add_pkt(2'b11, 8, 32'b00111111);
        add_idle(3);
        run_stream("t4_trailing_stuff");

        add_pkt(2'b01, 5, 32'b11111);
        add_pkt(2'b10, 2, 32'b11);
        add_idle(2);
        run_stream("t5_type_switch");

        last_t = 2'b00;
        for (int p = 0; p < 40; p++) begin
            gap = $urandom_range(0, 2);
            t   = 2'($urandom_range(1, 3));
            if (gap == 0 && t == last_t) t = (t == 2'd3) ? 2'd1 : t + 2'd1;
            add_idle(gap);
            add_rand_pkt(t, $urandom_range(1, 24));
            last_t = t;
        end
        add_idle(2);
        run_stream("rand");

        // Reset asserted while the stuffed bit is pending.
        bus.bstr_in       = 1'b1;
        bus.bstr_in_ready = 2'b01;
        repeat (6) @(negedge clk);
        check("t6_in_stuff", {bus.stall, bus.bstr_out, bus.bstr_out_ready}, 4'b1101);
        #1 rst_b = 1'b0;
        #1 check("t6_async_reset", {bus.stall, bus.bstr_out, bus.bstr_out_ready}, 4'b0100);
`ifdef BSTUFF_COUNT_EN
        check("t6_reset_cnt", stuff_count, 4'd0);
`endif
        bus.bstr_in       = 1'b0;
        bus.bstr_in_ready = 2'b00;
        @(negedge clk);
        check("t6_held_reset", {bus.stall, bus.bstr_out, bus.bstr_out_ready}, 4'b0100);
        rst_b = 1'b1;
        add_pkt(2'b01, 5, 32'b11111);
        add_idle(2);
        run_stream("t6_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
